// File: rtl/y0_dwa_encoder.sv
// y0 sample to unit-element DAC drive with data-weighted averaging, error count and stale flag.
// Define Y0_DWA_ROTATE_EN for DWA rotation; otherwise a static thermometer code is produced.
module y0_dwa_encoder #(
   parameter int Y0_W     = 4,
   parameter int N_EL     = 7,
   parameter int IDLE_MAX = 64,
   parameter int CNT_W    = 8
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      y0_valid_in,
   input  logic [Y0_W-1:0]           y0_data_in,
   output logic                      el_valid_out,
   output logic [N_EL-1:0]           el_data_out,
   output logic [$clog2(N_EL)-1:0]   ptr_out,
   output logic [CNT_W-1:0]          err_cnt_out,
   input  logic                      err_clr_in,
   output logic                      stale_out
);

   localparam int PTR_W  = $clog2(N_EL);
   localparam int K_W    = $clog2(N_EL + 1);
   localparam int SW     = Y0_W + 6;
   localparam int IDLE_W = $clog2(IDLE_MAX + 1);
   localparam logic signed [SW-1:0] NEL_S   = SW'(N_EL);
   localparam logic [CNT_W-1:0]     CNT_MAX = '1;
   localparam logic [IDLE_W-1:0]    IDLE_SAT = IDLE_W'(IDLE_MAX);

   logic signed [SW-1:0] x_ext;
   logic signed [SW-1:0] x_sum;
   logic [K_W-1:0]       k_nxt;
   logic                 ill_nxt;

   logic                 s1_valid;
   logic [K_W-1:0]       s1_k;
   logic [PTR_W-1:0]     ptr_q;
   logic [IDLE_W-1:0]    idle_cnt;
   logic [IDLE_W-1:0]    idle_nxt;

   logic [N_EL-1:0]      therm;
   logic [N_EL-1:0]      el_nxt;
   logic [PTR_W-1:0]     ptr_nxt;

   // level x maps to k = (x + N_EL) / 2 active elements; odd sums floor and are flagged
   always_comb begin
      x_ext   = {{(SW-Y0_W){y0_data_in[Y0_W-1]}}, y0_data_in};
      x_sum   = x_ext + NEL_S;
      k_nxt   = K_W'(x_sum >>> 1);
      ill_nxt = x_sum[0];
      if (x_ext > NEL_S) begin
         k_nxt   = K_W'(N_EL);
         ill_nxt = 1'b1;
      end else if (x_ext < -NEL_S) begin
         k_nxt   = '0;
         ill_nxt = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < N_EL; i++) begin
         therm[i] = (i < int'(s1_k));
      end
   end

`ifdef Y0_DWA_ROTATE_EN
   logic [2*N_EL-1:0]  therm_rot;
   logic [PTR_W+1:0]   ptr_sum;

   // rotate through a double-width vector so wrap-around bits fold back into the low half
   always_comb begin
      therm_rot = {{N_EL{1'b0}}, therm} << ptr_q;
      el_nxt    = therm_rot[N_EL-1:0] | therm_rot[2*N_EL-1:N_EL];
      ptr_sum   = (PTR_W+2)'(ptr_q) + (PTR_W+2)'(s1_k);
      ptr_nxt   = (ptr_sum >= (PTR_W+2)'(N_EL)) ? PTR_W'(ptr_sum - (PTR_W+2)'(N_EL))
                                                : PTR_W'(ptr_sum);
   end
`else
   always_comb begin
      el_nxt  = therm;
      ptr_nxt = '0;
   end
`endif

   always_comb begin
      if (y0_valid_in) begin
         idle_nxt = '0;
      end else if (idle_cnt == IDLE_SAT) begin
         idle_nxt = idle_cnt;
      end else begin
         idle_nxt = idle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid     <= 1'b0;
         s1_k         <= '0;
         el_valid_out <= 1'b0;
         el_data_out  <= '0;
         ptr_q        <= '0;
         err_cnt_out  <= '0;
         idle_cnt     <= '0;
         stale_out    <= 1'b0;
      end else begin
         s1_valid <= y0_valid_in;
         if (y0_valid_in) begin
            s1_k <= k_nxt;
         end

         el_valid_out <= s1_valid;
         if (s1_valid) begin
            el_data_out <= el_nxt;
            ptr_q       <= ptr_nxt;
         end

         // clear wins, but an illegal sample arriving with the clear still counts
         if (err_clr_in) begin
            err_cnt_out <= (y0_valid_in && ill_nxt) ? CNT_W'(1) : '0;
         end else if (y0_valid_in && ill_nxt && (err_cnt_out != CNT_MAX)) begin
            err_cnt_out <= err_cnt_out + 1'b1;
         end

         idle_cnt  <= idle_nxt;
         stale_out <= (idle_nxt == IDLE_SAT);
      end
   end

   assign ptr_out = ptr_q;

endmodule

// File: tb/tb_y0_dwa_encoder.sv
// Self-checking bench for y0_dwa_encoder: directed vector table, random back-to-back
// stream against a behavioural model, error saturation, stale flag and mid-flight reset.
module tb_y0_dwa_encoder;

   localparam int Y0_W     = 4;
   localparam int N_EL     = 7;
   localparam int IDLE_MAX = 64;
   localparam int CNT_W    = 8;

   logic                  clock;
   logic                  reset;
   logic                  y0_valid_in;
   logic [Y0_W-1:0]       y0_data_in;
   logic                  el_valid_out;
   logic [N_EL-1:0]       el_data_out;
   logic [2:0]            ptr_out;
   logic [CNT_W-1:0]      err_cnt_out;
   logic                  err_clr_in;
   logic                  stale_out;

   int n_tests = 0;
   int n_fail  = 0;
   int ptr_ref = 0;
   int err_ref = 0;

`ifdef Y0_DWA_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   y0_dwa_encoder #(
      .Y0_W(Y0_W), .N_EL(N_EL), .IDLE_MAX(IDLE_MAX), .CNT_W(CNT_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .y0_valid_in (y0_valid_in),
      .y0_data_in  (y0_data_in),
      .el_valid_out(el_valid_out),
      .el_data_out (el_data_out),
      .ptr_out     (ptr_out),
      .err_cnt_out (err_cnt_out),
      .err_clr_in  (err_clr_in),
      .stale_out   (stale_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int             x;
      logic [N_EL-1:0] el_rot;
      int             ptr_rot;
      logic [N_EL-1:0] el_sta;
      int             err;
   } vec_t;

   typedef struct {
      logic [N_EL-1:0] el;
      int             ptr;
      int             k;
   } exp_t;

   vec_t vecs[8];
   exp_t exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int k_of(input int x);
      if (x > N_EL) return N_EL;
      if (x < -N_EL) return 0;
      return (x + N_EL) / 2;
   endfunction

   function automatic bit illegal_of(input int x);
      return (x > N_EL) || (x < -N_EL) || (((x + N_EL) % 2) != 0);
   endfunction

   function automatic logic [N_EL-1:0] el_of(input int k, input int p);
      logic [N_EL-1:0] e;
      e = '0;
      for (int j = 0; j < k; j++) begin
         if (ROT) e[(p + j) % N_EL] = 1'b1;
         else     e[j] = 1'b1;
      end
      return e;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      logic [N_EL-1:0] el_exp;
      int              ptr_exp;
      string           nm;
      el_exp  = ROT ? v.el_rot : v.el_sta;
      ptr_exp = ROT ? v.ptr_rot : 0;
      nm = $sformatf("vec%0d x=%0d", idx, v.x);
      @(negedge clock);
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(v.x);
      @(negedge clock);
      y0_valid_in = 1'b0;
      chk({nm, " valid t+1"}, 32'(el_valid_out), 0);
      @(negedge clock);
      chk({nm, " valid t+2"}, 32'(el_valid_out), 1);
      chk({nm, " el"}, 32'(el_data_out), 32'(el_exp));
      chk({nm, " ptr"}, 32'(ptr_out), 32'(ptr_exp));
      chk({nm, " err"}, 32'(err_cnt_out), 32'(v.err));
      @(negedge clock);
      chk({nm, " valid t+3"}, 32'(el_valid_out), 0);
      chk({nm, " el hold"}, 32'(el_data_out), 32'(el_exp));
   endtask

   initial begin
      int   pulses;
      int   k;
      int   x;
      exp_t e;

      vecs[0] = '{ 1, 7'b0001111, 4, 7'b0001111, 0};
      vecs[1] = '{ 3, 7'b1110011, 2, 7'b0011111, 0};
      vecs[2] = '{-7, 7'b0000000, 2, 7'b0000000, 0};
      vecs[3] = '{ 7, 7'b1111111, 2, 7'b1111111, 0};
      vecs[4] = '{ 2, 7'b0111100, 6, 7'b0001111, 1};
      vecs[5] = '{-8, 7'b0000000, 6, 7'b0000000, 2};
      vecs[6] = '{-1, 7'b1000011, 2, 7'b0000111, 2};
      vecs[7] = '{-5, 7'b0000100, 3, 7'b0000001, 2};

      reset       = 1'b1;
      y0_valid_in = 1'b0;
      y0_data_in  = '0;
      err_clr_in  = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset el_valid", 32'(el_valid_out), 0);
      chk("reset el_data", 32'(el_data_out), 0);
      chk("reset ptr", 32'(ptr_out), 0);
      chk("reset err", 32'(err_cnt_out), 0);
      chk("reset stale", 32'(stale_out), 0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
      ptr_ref = ROT ? vecs[7].ptr_rot : 0;
      err_ref = vecs[7].err;

      // full-throughput random legal stream against the model
      pulses = 0;
      for (int c = 0; c < 106; c++) begin
         @(negedge clock);
         if (el_valid_out) begin
            pulses++;
            if (exp_q.size() == 0) begin
               chk("stream unexpected pulse", 32'(pulses), 0);
            end else begin
               e = exp_q.pop_front();
               chk("stream el", 32'(el_data_out), 32'(e.el));
               chk("stream ptr", 32'(ptr_out), 32'(e.ptr));
               chk("stream popcount", 32'($countones(el_data_out)), 32'(e.k));
            end
         end
         if (c < 100) begin
            k = int'($urandom_range(0, N_EL));
            x = 2 * k - N_EL;
            y0_valid_in = 1'b1;
            y0_data_in  = 4'(x);
            e.k   = k_of(x);
            e.el  = el_of(e.k, ptr_ref);
            if (ROT) ptr_ref = (ptr_ref + e.k) % N_EL;
            e.ptr = ptr_ref;
            exp_q.push_back(e);
         end else begin
            y0_valid_in = 1'b0;
         end
      end
      chk("stream pulse count", 32'(pulses), 100);
      chk("stream queue drained", 32'(exp_q.size()), 0);
      chk("stream err unchanged", 32'(err_cnt_out), 32'(err_ref));

      // error counter saturation with k=0 samples that leave the pointer alone
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         y0_valid_in = 1'b1;
         y0_data_in  = 4'(-8);
         if (illegal_of(-8) && err_ref < 255) err_ref++;
      end
      @(negedge clock);
      y0_valid_in = 1'b0;
      repeat (3) @(negedge clock);
      chk("err saturated", 32'(err_cnt_out), 32'(err_ref));
      chk("err sat ptr", 32'(ptr_out), 32'(ptr_ref));
      chk("err sat el zero", 32'(el_data_out), 0);
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(-8);
      err_clr_in  = 1'b1;
      @(negedge clock);
      y0_valid_in = 1'b0;
      err_clr_in  = 1'b0;
      chk("err clr with illegal", 32'(err_cnt_out), 1);
      err_clr_in = 1'b1;
      @(negedge clock);
      err_clr_in = 1'b0;
      chk("err clr alone", 32'(err_cnt_out), 0);
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(4);
      @(negedge clock);
      y0_valid_in = 1'b0;
      chk("err parity count", 32'(err_cnt_out), 1);

      // stale flag: legal k=0 samples keep the pointer where it is
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(-7);
      @(negedge clock);
      y0_valid_in = 1'b0;
      chk("stale after sample", 32'(stale_out), 0);
      repeat (IDLE_MAX - 1) @(negedge clock);
      chk("stale at idle-1", 32'(stale_out), 0);
      @(negedge clock);
      chk("stale at idle", 32'(stale_out), 1);
      repeat (10) @(negedge clock);
      chk("stale held", 32'(stale_out), 1);
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(-7);
      @(negedge clock);
      y0_valid_in = 1'b0;
      chk("stale cleared", 32'(stale_out), 0);
      repeat (3) @(negedge clock);

      // reset between sample and output must swallow the pulse
      y0_valid_in = 1'b1;
      y0_data_in  = 4'(1);
      @(negedge clock);
      y0_valid_in = 1'b0;
      reset       = 1'b1;
      @(negedge clock);
      reset  = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (el_valid_out) pulses++;
      end
      chk("reset inflight pulses", 32'(pulses), 0);
      chk("reset inflight el", 32'(el_data_out), 0);
      chk("reset inflight ptr", 32'(ptr_out), 0);
      chk("reset inflight err", 32'(err_cnt_out), 0);
      ptr_ref = 0;

      // first sample after reset restarts the rotation from element 0
      run_vec(vecs[0], 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
